// File: rtl/stopwatch.sv
// rtl/stopwatch.sv - 4-digit BCD stopwatch (SS.hh) with multiplexed 7-segment display
// Prescaled 10 ms tick drives a BCD carry chain; a free-running refresh counter scans the digits.
module stopwatch #(
  parameter int TICK_DIV     = 1_000_000,
  parameter int REFRESH_BITS = 18
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic       d,
  output logic       e,
  output logic       f,
  output logic       g,
  output logic       dp,
  output logic [3:0] an,
  output logic       led
);

  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);

  logic [PW-1:0]           pre_q, pre_d;
  logic [3:0]              dig_q [4];
  logic [3:0]              dig_d [4];
  logic [REFRESH_BITS-1:0] refresh_q, refresh_d;
  logic                    led_q, led_d;
  logic                    tick;
  logic                    carry;

  // The prescaler only advances while running, so a pause resumes mid-interval.
  always_comb begin
    pre_d     = pre_q;
    tick      = 1'b0;
    dig_d     = dig_q;
    carry     = 1'b0;
    refresh_d = refresh_q + REFRESH_BITS'(1);
    led_d     = start;
    if (start) begin
      if (pre_q == PRE_MAX) begin
        pre_d = '0;
        tick  = 1'b1;
      end else begin
        pre_d = pre_q + PW'(1);
      end
    end
    carry = tick;
    for (int i = 0; i < 4; i++) begin
      if (carry) begin
        if (dig_q[i] == 4'd9) begin
          dig_d[i] = 4'd0;
        end else begin
          dig_d[i] = dig_q[i] + 4'd1;
          carry    = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pre_q     <= '0;
      refresh_q <= '0;
      led_q     <= 1'b0;
      for (int i = 0; i < 4; i++) dig_q[i] <= 4'd0;
    end else begin
      pre_q     <= pre_d;
      refresh_q <= refresh_d;
      led_q     <= led_d;
      for (int i = 0; i < 4; i++) dig_q[i] <= dig_d[i];
    end
  end

  logic [1:0] sel;
  logic [3:0] cur;
  logic [6:0] seg;

  assign sel = refresh_q[REFRESH_BITS-1 -: 2];
  assign cur = dig_q[sel];

  always_comb begin
    an = 4'b1111;
    an[sel] = 1'b0;
    dp = (sel != 2'd2);
  end

  always_comb begin
    unique case (cur)
      4'd0:    seg = 7'b0000001;
      4'd1:    seg = 7'b1001111;
      4'd2:    seg = 7'b0010010;
      4'd3:    seg = 7'b0000110;
      4'd4:    seg = 7'b1001100;
      4'd5:    seg = 7'b0100100;
      4'd6:    seg = 7'b0100000;
      4'd7:    seg = 7'b0001111;
      4'd8:    seg = 7'b0000000;
      4'd9:    seg = 7'b0000100;
      default: seg = 7'b1111111;
    endcase
  end

  assign {a, b, c, d, e, f, g} = seg;
  assign led = led_q;

endmodule

// File: tb/tb_stopwatch.sv
// tb/tb_stopwatch.sv - self-checking bench for stopwatch
// Every cycle is checked against a count-level model; table rows also read the display back as BCD.
module tb_stopwatch;

  localparam int TD = 4;
  localparam int RB = 4;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       a, b, c, d, e, f, g, dp, led;
  logic [3:0] an;

  stopwatch #(.TICK_DIV(TD), .REFRESH_BITS(RB)) dut (
    .clock(clock), .reset(reset), .start(start),
    .a(a), .b(b), .c(c), .d(d), .e(e), .f(f), .g(g),
    .dp(dp), .an(an), .led(led)
  );

  always #5 clock = ~clock;

  logic [6:0] seg_tbl [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
                               7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100};
  int p10 [4] = '{1, 10, 100, 1000};

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  bit armed = 0;

  int m_cnt, m_pre, m_ref;
  bit m_led;

  typedef struct {
    bit          rst;
    bit          st;
    int          cycles;
    logic [15:0] exp_bcd;
    string       name;
  } vec_t;

  vec_t vecs [14];

  task automatic model_update(input bit r, input bit s);
    if (r) begin
      m_cnt = 0; m_pre = 0; m_ref = 0; m_led = 0;
    end else begin
      m_ref = (m_ref + 1) % (1 << RB);
      m_led = s;
      if (s) begin
        if (m_pre == TD - 1) begin
          m_pre = 0;
          m_cnt = (m_cnt + 1) % 10000;
        end else begin
          m_pre = m_pre + 1;
        end
      end
    end
  endtask

  task automatic check_outputs();
    int sel, dig;
    logic [3:0]  exp_an;
    logic [12:0] exp_v, act_v;
    sel    = m_ref >> (RB - 2);
    dig    = (m_cnt / p10[sel]) % 10;
    exp_an = 4'b1111;
    exp_an[sel] = 1'b0;
    exp_v  = {exp_an, seg_tbl[dig], (sel != 2), m_led};
    act_v  = {an, a, b, c, d, e, f, g, dp, led};
    n_cmp++;
    if (act_v !== exp_v) begin
      n_bad++;
      $display("FAIL outputs cyc=%0d actual={an,seg,dp,led}=%b required=%b", cyc, act_v, exp_v);
    end
  endtask

  task automatic step(input bit r, input bit s);
    reset = r;
    start = s;
    @(posedge clock);
    cyc++;
    model_update(r, s);
    if (r) armed = 1;
    @(negedge clock);
    if (armed) check_outputs();
  endtask

  function automatic logic [3:0] decode(input logic [6:0] s);
    logic [3:0] v;
    v = 4'hF;
    for (int k = 0; k < 10; k++) if (seg_tbl[k] == s) v = 4'(k);
    return v;
  endfunction

  // Paused scan over a full refresh period, rebuilding the shown value from segments and anodes.
  task automatic scan_check(input logic [15:0] exp_bcd, input string name);
    logic [15:0] got;
    got = 16'hFFFF;
    for (int k = 0; k < (1 << RB); k++) begin
      step(0, 0);
      for (int j = 0; j < 4; j++)
        if (an == ~(4'b0001 << j)) got[j*4 +: 4] = decode({a, b, c, d, e, f, g});
    end
    n_cmp++;
    if (got !== exp_bcd) begin
      n_bad++;
      $display("FAIL %s actual=%h required=%h", name, got, exp_bcd);
    end
  endtask

  initial begin
    vecs[0]  = '{1, 0, 5,     16'h0000, "reset_hold"};
    vecs[1]  = '{0, 0, 20,    16'h0000, "idle"};
    vecs[2]  = '{0, 1, 148,   16'h0037, "count_37"};
    vecs[3]  = '{0, 1, 4788,  16'h1234, "count_1234"};
    vecs[4]  = '{1, 1, 1,     16'h0000, "reset_mid_count"};
    vecs[5]  = '{0, 1, 3,     16'h0000, "first_tick_wait"};
    vecs[6]  = '{0, 1, 1,     16'h0001, "first_tick"};
    vecs[7]  = '{0, 1, 18,    16'h0005, "to_05"};
    vecs[8]  = '{0, 0, 50,    16'h0005, "pause_hold"};
    vecs[9]  = '{0, 1, 1,     16'h0005, "resume_partial"};
    vecs[10] = '{0, 1, 1,     16'h0006, "resume_tick"};
    vecs[11] = '{0, 1, 39988, 16'h0003, "wrap_9999"};
    vecs[12] = '{1, 0, 3,     16'h0000, "reset_idle"};
    vecs[13] = '{0, 0, 4,     16'h0000, "after_reset_idle"};

    for (int v = 0; v < 14; v++) begin
      for (int k = 0; k < vecs[v].cycles; k++) step(vecs[v].rst, vecs[v].st);
      scan_check(vecs[v].exp_bcd, vecs[v].name);
    end

    for (int k = 0; k < 3000; k++)
      step($urandom_range(0, 199) == 0, $urandom_range(0, 3) != 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/stopwatch.md
Name: stopwatch

Overview:
- 4-digit BCD stopwatch for a 100 MHz board clock.
- Counts hundredths of a second from 00.00 to 99.99 while `start` is high, and holds the count while `start` is low.
- Drives a multiplexed, common-anode 4-digit 7-segment display with active-low segments and anodes, plus a "running" LED.
- Top-level user block; connects directly to board pins.

Parameters:
- TICK_DIV, 1_000_000: clock cycles per count increment (10 ms at 100 MHz); must be ≥2.
- REFRESH_BITS, 18: width of the free-running display-refresh counter; its top 2 bits select the digit.

Ports:
- clock  input  1  system clock, rising-edge; all state changes on this edge.
- reset  input  1  synchronous, active-high; clears all state.
- start  input  1  level-sensitive run enable: 1 = count, 0 = pause/hold.
- a  output  1  segment a, active-low.
- b  output  1  segment b, active-low.
- c  output  1  segment c, active-low.
- d  output  1  segment d, active-low.
- e  output  1  segment e, active-low.
- f  output  1  segment f, active-low.
- g  output  1  segment g, active-low.
- dp  output  1  decimal point, active-low.
- an  output  4  digit anodes, active-low; an[3] = leftmost digit.
- led  output  1  1 while counting is enabled.

Behaviour:
- Single clock domain: `clock`. `reset` is synchronous and active-high; it is sampled only on the rising edge of `clock`.
- Reset clears:
  - prescaler = 0;
  - digits d3..d0 = 0;
  - refresh counter = 0;
  - led = 0.
- Outputs after reset:
  - an = 4'b1110;
  - segments show "0", i.e. {a,b,c,d,e,f,g} = 0000001;
  - dp = 1 (off).
- Reset has priority over `start`. Asserting reset mid-count returns the display to 00.00 on the next edge. Counting resumes only after reset deasserts and `start` = 1.
- Prescaler:
  - Counts 0..TICK_DIV-1 while start=1 and reset=0.
  - On reaching TICK_DIV-1 it wraps to 0 and asserts a one-cycle `tick`.
  - When start=0 the prescaler holds its value; it is not cleared. The current 10 ms interval therefore resumes where it paused.
- Digit counters (BCD, each 0..9):
  - d0 = hundredths, d1 = tenths, d2 = seconds units, d3 = seconds tens.
  - On each tick, d0 increments. A 9→0 rollover carries into the next digit in the same cycle.
  - 99.99 + tick → 00.00 (full wrap, no halt, no flag).
  - The first increment occurs TICK_DIV cycles after start first goes high following reset.
- Pause: while start=0, all digits hold; display refresh and multiplexing continue.
- led: registered copy of (start & ~reset); 1-cycle latency.
- Display multiplexing:
  - The refresh counter always increments, including while paused; only reset clears it.
  - sel = refresh[REFRESH_BITS-1 : REFRESH_BITS-2].
  - sel=0 → an=1110, digit d0.
  - sel=1 → an=1101, digit d1.
  - sel=2 → an=1011, digit d2, dp=0 (lit), giving the display format "SS.hh".
  - sel=3 → an=0111, digit d3.
  - dp=1 for all sel other than 2.
  - Exactly one anode is low at any time.
- Segment decode, {a..g} for each digit value:
  - 0 → 0000001
  - 1 → 1001111
  - 2 → 0010010
  - 3 → 0000110
  - 4 → 1001100
  - 5 → 0100100
  - 6 → 0100000
  - 7 → 0001111
  - 8 → 0000000
  - 9 → 0000100
  - Any non-BCD value → 1111111 (blank); unreachable in normal operation.
- Segment, an and dp outputs are combinational from registered state (sel and the digits) and glitch-free relative to the clock edge. The counter value shown on a digit changes in the same cycle the digit register updates.

Test Plan (sim with TICK_DIV=4, REFRESH_BITS=4):
- Hold reset 5 cycles, release, start=0 for 20 cycles → digits stay 00.00, led=0, an cycles 1110→1101→1011→0111 every 4 cycles, dp low only when an=1011, segments = 0000001 on every digit.
- start=1 for 4×37 cycles → d3..d0 = 0,0,3,7; led=1 one cycle after start rises; the d0 9→0 carry increments d1 in the same cycle.
- start=1 through 10000 ticks → 99.99 wraps to 00.00, counting continues.
- Running with count = 00.05, drop start for 50 cycles, then raise it → count holds at 00.05 while low; the next increment occurs after the remaining prescaler cycles (no lost or extra tick).
- Assert reset for one cycle with start=1 at count 12.34 → next edge shows 00.00, led=0, prescaler=0; after release, the first tick arrives 4 cycles later.
- Assert reset with start=0, then release → led stays 0, digits stay 0, refresh restarts at an=1110.
